// File: rtl/nav_pkg.sv
// Shared types for the line-following navigation stage: drive states,
// status display codes and the sensor-pattern decode table.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FORWARD,
    TURN_LEFT,
    TURN_RIGHT,
    CROSSING,
    LOST
  } nav_state_e;

  localparam logic [1:0] SIG_OFF    = 2'b00;
  localparam logic [1:0] SIG_ACTIVE = 2'b01;
  localparam logic [1:0] SIG_HOLD   = 2'b10;

  // Map filtered {L,C,R} to the next drive state; 101 keeps the current state.
  function automatic nav_state_e pattern_state(input logic [2:0] lcr, input nav_state_e cur);
    nav_state_e ns;
    ns = cur;
    case (lcr)
      3'b010:         ns = FORWARD;
      3'b100, 3'b110: ns = TURN_LEFT;
      3'b001, 3'b011: ns = TURN_RIGHT;
      3'b111:         ns = CROSSING;
      3'b000:         ns = LOST;
      default:        ns = cur;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability filter: the output follows
// the synchronized level only after it has differed for DEB_CYCLES clocks.
module sensor_debounce #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count while the synchronized level disagrees with the filtered one;
  // any return to the filtered level restarts the count.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/nav_sequencer.sv
// Line-following drive sequencer: filters the IR tape sensors, steps the
// drive state machine and produces gated motor PWM plus display status codes.
module nav_sequencer
  import nav_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 100000,
  parameter int unsigned PWM_PERIOD  = 100000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned LOST_CYCLES = 100000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       stop_req,
  input  logic       ir_left,
  input  logic       ir_center,
  input  logic       ir_right,
  input  logic [1:0] duty_sel,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic       dir_a,
  output logic       dir_b,
  output logic [1:0] forward_signal,
  output logic [1:0] left_signal,
  output logic [1:0] right_signal,
  output logic       lost
);

  localparam int unsigned PCW     = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned TW      = PCW + 1;
  localparam int unsigned QUARTER = PWM_PERIOD / 4;
  localparam int unsigned HCW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned LCW     = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;

  logic filt_l, filt_c, filt_r;
  logic [2:0] lcr_c;

  nav_state_e     state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [LCW-1:0] lost_cnt_q, lost_cnt_d;
  logic           lost_q, lost_d;
  logic [PCW-1:0] cnt_q, cnt_d;
  logic [1:0]     duty_lat_q, duty_lat_d;
  logic           pwm_a_q, pwm_a_d;
  logic           pwm_b_q, pwm_b_d;
  logic           dir_q, dir_d;
  logic [1:0]     fwd_q, fwd_d;
  logic [1:0]     left_q, left_d;
  logic [1:0]     right_q, right_d;

  logic           wrap_c;
  logic [TW-1:0]  thr_c;
  logic           pwm_c;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clock (clock),
    .resetn(resetn),
    .din   (ir_left),
    .dout  (filt_l)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_center (
    .clock (clock),
    .resetn(resetn),
    .din   (ir_center),
    .dout  (filt_c)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clock (clock),
    .resetn(resetn),
    .din   (ir_right),
    .dout  (filt_r)
  );

  assign lcr_c = {filt_l, filt_c, filt_r};

  // Free-running PWM counter; duty is only sampled at wrap so a period is never cut short.
  assign wrap_c = (cnt_q == PCW'(PWM_PERIOD - 1));
  assign thr_c  = TW'(QUARTER * (32'(duty_lat_q) + 32'd1));
  assign pwm_c  = ({1'b0, cnt_q} < thr_c);

  always_comb begin
    cnt_d      = wrap_c ? '0 : cnt_q + PCW'(1);
    duty_lat_d = wrap_c ? duty_sel : duty_lat_q;
  end

  // Next-state logic; timers default to zero so leaving a state clears them.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    lost_cnt_d = '0;
    lost_d     = lost_q;
    if (!enable || stop_req) begin
      state_d = IDLE;
      if (!enable) begin
        lost_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!lost_q) begin
            state_d = pattern_state(lcr_c, IDLE);
          end
        end
        FORWARD, TURN_LEFT, TURN_RIGHT: begin
          state_d = pattern_state(lcr_c, state_q);
        end
        CROSSING: begin
          if (hold_cnt_q == HCW'(HOLD_CYCLES - 1)) begin
            state_d = FORWARD;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end
        LOST: begin
          if (lcr_c != 3'b000 && lcr_c != 3'b101) begin
            state_d = pattern_state(lcr_c, LOST);
          end else if (lost_cnt_q == LCW'(LOST_CYCLES - 1)) begin
            state_d = IDLE;
            lost_d  = 1'b1;
          end else begin
            lost_cnt_d = lost_cnt_q + LCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the current state, registered one clock behind it.
  always_comb begin
    pwm_a_d = 1'b0;
    pwm_b_d = 1'b0;
    dir_d   = 1'b1;
    fwd_d   = SIG_OFF;
    left_d  = SIG_OFF;
    right_d = SIG_OFF;
    case (state_q)
      IDLE:    dir_d = 1'b0;
      FORWARD: begin
        pwm_a_d = pwm_c;
        pwm_b_d = pwm_c;
        fwd_d   = SIG_ACTIVE;
      end
      TURN_LEFT: begin
        pwm_b_d = pwm_c;
        left_d  = SIG_ACTIVE;
      end
      TURN_RIGHT: begin
        pwm_a_d = pwm_c;
        right_d = SIG_ACTIVE;
      end
      CROSSING: begin
        pwm_a_d = pwm_c;
        pwm_b_d = pwm_c;
        fwd_d   = SIG_HOLD;
        left_d  = SIG_HOLD;
        right_d = SIG_HOLD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      lost_cnt_q <= '0;
      lost_q     <= 1'b0;
      cnt_q      <= '0;
      duty_lat_q <= 2'b00;
      pwm_a_q    <= 1'b0;
      pwm_b_q    <= 1'b0;
      dir_q      <= 1'b0;
      fwd_q      <= SIG_OFF;
      left_q     <= SIG_OFF;
      right_q    <= SIG_OFF;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      lost_q     <= lost_d;
      cnt_q      <= cnt_d;
      duty_lat_q <= duty_lat_d;
      pwm_a_q    <= pwm_a_d;
      pwm_b_q    <= pwm_b_d;
      dir_q      <= dir_d;
      fwd_q      <= fwd_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign pwm_a          = pwm_a_q;
  assign pwm_b          = pwm_b_q;
  assign dir_a          = dir_q;
  assign dir_b          = dir_q;
  assign forward_signal = fwd_q;
  assign left_signal    = left_q;
  assign right_signal   = right_q;
  assign lost           = lost_q;

endmodule

// File: tb/tb_nav_sequencer.sv
// Bench for nav_sequencer: directed scenarios plus random sensor traffic,
// checked every cycle against a cycle-count based behavioural model.
module tb_nav_sequencer;

  localparam int DEB   = 4;
  localparam int PWM_P = 8;
  localparam int HOLD  = 16;
  localparam int LOSTC = 20;

  localparam int S_IDLE  = 0;
  localparam int S_FWD   = 1;
  localparam int S_LEFT  = 2;
  localparam int S_RIGHT = 3;
  localparam int S_CROSS = 4;
  localparam int S_LOST  = 5;

  logic       clock;
  logic       resetn;
  logic       enable;
  logic       stop_req;
  logic       ir_left, ir_center, ir_right;
  logic [1:0] duty_sel;
  logic       pwm_a, pwm_b, dir_a, dir_b, lost;
  logic [1:0] forward_signal, left_signal, right_signal;

  int n_cmp = 0;
  int n_bad = 0;

  nav_sequencer #(
    .DEB_CYCLES (DEB),
    .PWM_PERIOD (PWM_P),
    .HOLD_CYCLES(HOLD),
    .LOST_CYCLES(LOSTC)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .enable        (enable),
    .stop_req      (stop_req),
    .ir_left       (ir_left),
    .ir_center     (ir_center),
    .ir_right      (ir_right),
    .duty_sel      (duty_sel),
    .pwm_a         (pwm_a),
    .pwm_b         (pwm_b),
    .dir_a         (dir_a),
    .dir_b         (dir_b),
    .forward_signal(forward_signal),
    .left_signal   (left_signal),
    .right_signal  (right_signal),
    .lost          (lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wire [10:0] dut_v = {pwm_a, pwm_b, dir_a, dir_b, forward_signal, left_signal, right_signal, lost};
  wire all_hold = (forward_signal == 2'b10) && (left_signal == 2'b10) && (right_signal == 2'b10);
  wire lost_look = dir_a && !pwm_a && !pwm_b && forward_signal == 2'b00 &&
                   left_signal == 2'b00 && right_signal == 2'b00;

  // ---------------- behavioural model ----------------
  int         m_state, m_entry, m_cyc, ns;
  logic       m_lost;
  logic [1:0] m_duty;
  logic [2:0] m_filt, nf;
  logic [2:0] rawh [0:7];
  logic [9:0] o;
  logic       pw;
  bit         same;
  logic [10:0] mdl_v;

  function automatic int table_state(input logic [2:0] p, input int cur);
    if (p == 3'b010) return S_FWD;
    if (p == 3'b100 || p == 3'b110) return S_LEFT;
    if (p == 3'b001 || p == 3'b011) return S_RIGHT;
    if (p == 3'b111) return S_CROSS;
    if (p == 3'b000) return S_LOST;
    return cur;
  endfunction

  // rawh[j] holds the sensor sample taken j+1 edges ago; time in a state is measured
  // from the edge count at which the state was entered.
  always @(posedge clock) begin
    if (!resetn) begin
      m_state = S_IDLE; m_entry = 0; m_cyc = 0; m_lost = 1'b0;
      m_duty = 2'b00; m_filt = 3'b000; mdl_v = '0;
      for (int j = 0; j < 8; j++) rawh[j] = 3'b000;
    end else begin
      pw = (m_cyc % PWM_P) < (PWM_P / 4) * (int'(m_duty) + 1);
      case (m_state)
        S_FWD:   o = {pw, pw, 2'b11, 2'b01, 2'b00, 2'b00};
        S_LEFT:  o = {1'b0, pw, 2'b11, 2'b00, 2'b01, 2'b00};
        S_RIGHT: o = {pw, 1'b0, 2'b11, 2'b00, 2'b00, 2'b01};
        S_CROSS: o = {pw, pw, 2'b11, 2'b10, 2'b10, 2'b10};
        S_LOST:  o = {2'b00, 2'b11, 6'b000000};
        default: o = '0;
      endcase
      nf = m_filt;
      for (int b = 0; b < 3; b++) begin
        same = 1'b1;
        for (int j = 2; j <= DEB; j++) if (rawh[j][b] !== rawh[1][b]) same = 1'b0;
        if (same && rawh[1][b] !== m_filt[b]) nf[b] = rawh[1][b];
      end
      ns = m_state;
      if (!enable || stop_req) begin
        ns = S_IDLE;
        if (!enable) m_lost = 1'b0;
      end else if (m_state == S_CROSS) begin
        if (m_cyc - m_entry == HOLD) ns = S_FWD;
      end else if (m_state == S_LOST) begin
        if (m_filt != 3'b000 && m_filt != 3'b101) ns = table_state(m_filt, S_LOST);
        else if (m_cyc - m_entry == LOSTC) begin ns = S_IDLE; m_lost = 1'b1; end
      end else if (m_state == S_IDLE) begin
        if (!m_lost) ns = table_state(m_filt, S_IDLE);
      end else begin
        ns = table_state(m_filt, m_state);
      end
      if (ns != m_state) m_entry = m_cyc;
      m_state = ns;
      m_filt  = nf;
      if (m_cyc % PWM_P == PWM_P - 1) m_duty = duty_sel;
      for (int j = 7; j > 0; j--) rawh[j] = rawh[j-1];
      rawh[0] = {ir_left, ir_center, ir_right};
      m_cyc++;
      mdl_v = {o, m_lost};
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; stop_req = 1'b0; duty_sel = 2'b01;
    {ir_left, ir_center, ir_right} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== 11'd0) begin n_bad++; $display("FAIL reset_outputs: got %b expected %b", dut_v, 11'd0); end
    end
    resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL reset_model k=%0d: got %b expected %b", k, dut_v, mdl_v); end
      n_cmp++;
      if (all_hold !== (k >= 8)) begin n_bad++; $display("FAIL reset_hold_latency k=%0d: got %b expected %b", k, all_hold, (k >= 8)); end
    end
  endtask

  task automatic test_forward();
    int ha, hb;
    {ir_left, ir_center, ir_right} = 3'b010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL forward_model: got %b expected %b", dut_v, mdl_v); end
    end
    ha = 0; hb = 0;
    for (int i = 0; i < PWM_P; i++) begin
      @(negedge clock);
      ha += int'(pwm_a); hb += int'(pwm_b);
    end
    n_cmp++;
    if (ha != 4 || hb != 4) begin n_bad++; $display("FAIL forward_duty50: got %0d/%0d expected 4/4", ha, hb); end
    n_cmp++;
    if ({forward_signal, dir_a, dir_b} !== 4'b0111) begin
      n_bad++; $display("FAIL forward_status: got %b expected 0111", {forward_signal, dir_a, dir_b});
    end
  endtask

  task automatic test_turn_left();
    int hb;
    {ir_left, ir_center, ir_right} = 3'b110;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL left_model: got %b expected %b", dut_v, mdl_v); end
    end
    {ir_left, ir_center, ir_right} = 3'b001;
    @(negedge clock);
    @(negedge clock);
    {ir_left, ir_center, ir_right} = 3'b110;
    hb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      hb += int'(pwm_b);
      n_cmp++;
      if (left_signal !== 2'b01 || pwm_a !== 1'b0) begin
        n_bad++; $display("FAIL left_glitch_ignored: got left=%b pwm_a=%b expected 01/0", left_signal, pwm_a);
      end
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL left_glitch_model: got %b expected %b", dut_v, mdl_v); end
    end
    n_cmp++;
    if (hb != 8) begin n_bad++; $display("FAIL left_pwm_b: got %0d high expected 8", hb); end
  endtask

  task automatic test_crossing();
    bit found;
    int run;
    {ir_left, ir_center, ir_right} = 3'b111;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL cross_model: got %b expected %b", dut_v, mdl_v); end
      if (all_hold) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL cross_enter: got no hold expected hold within 40 clocks"); end
    run = 0;
    if (found) begin
      run = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        n_cmp++;
        if (dut_v !== mdl_v) begin n_bad++; $display("FAIL cross_model: got %b expected %b", dut_v, mdl_v); end
        if (all_hold) run++;
        else break;
      end
    end
    n_cmp++;
    if (run != HOLD) begin n_bad++; $display("FAIL cross_length: got %0d expected %0d", run, HOLD); end
    n_cmp++;
    if (forward_signal !== 2'b01) begin n_bad++; $display("FAIL cross_exit: got %b expected 01", forward_signal); end
    @(negedge clock);
    n_cmp++;
    if (!all_hold) begin n_bad++; $display("FAIL cross_reenter: got %b expected 10", forward_signal); end
  endtask

  task automatic test_lost();
    int  nl;
    bit  seen;
    {ir_left, ir_center, ir_right} = 3'b000;
    nl = 0; seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL lost_model: got %b expected %b", dut_v, mdl_v); end
      if (lost_look) nl++;
      if (lost) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || nl != LOSTC) begin n_bad++; $display("FAIL lost_timeout: got seen=%0d cycles=%0d expected 1/%0d", seen, nl, LOSTC); end
    {ir_left, ir_center, ir_right} = 3'b010;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({lost, dir_a, forward_signal, pwm_a} !== 5'b10000) begin
        n_bad++; $display("FAIL lost_sticky: got %b expected 10000", {lost, dir_a, forward_signal, pwm_a});
      end
    end
    enable = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (lost !== 1'b0) begin n_bad++; $display("FAIL lost_clear: got %b expected 0", lost); end
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (forward_signal !== 2'b01) begin n_bad++; $display("FAIL lost_resume: got %b expected 01", forward_signal); end
  endtask

  task automatic test_stop_and_duty();
    bit at4;
    duty_sel = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL stop_model: got %b expected %b", dut_v, mdl_v); end
    end
    n_cmp++;
    if ({pwm_a, pwm_b} !== 2'b11) begin n_bad++; $display("FAIL duty100: got %b expected 11", {pwm_a, pwm_b}); end
    stop_req = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (pwm_a !== 1'b1) begin n_bad++; $display("FAIL stop_lag: got %b expected 1", pwm_a); end
    stop_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({pwm_a, pwm_b, dir_a} !== 3'b000) begin n_bad++; $display("FAIL stop_off: got %b expected 000", {pwm_a, pwm_b, dir_a}); end
    duty_sel = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL duty_model: got %b expected %b", dut_v, mdl_v); end
    end
    at4 = 1'b0;
    for (int i = 0; i < 10 && !at4; i++) begin
      @(negedge clock);
      if (m_cyc % PWM_P == 4) at4 = 1'b1;
    end
    n_cmp++;
    if (!at4) begin n_bad++; $display("FAIL duty_align: got none expected counter 4"); end
    duty_sel = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_cmp++;
      if (pwm_a !== (i >= 4)) begin n_bad++; $display("FAIL duty_at_wrap i=%0d: got %b expected %b", i, pwm_a, (i >= 4)); end
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 160; seg++) begin
      {ir_left, ir_center, ir_right} = 3'($urandom_range(0, 7));
      len      = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(1, 14);
      enable   = ($urandom_range(0, 15) != 0);
      stop_req = ($urandom_range(0, 15) == 0);
      duty_sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        @(negedge clock);
        n_cmp++;
        if (dut_v !== mdl_v) begin n_bad++; $display("FAIL random_model seg=%0d: got %b expected %b", seg, dut_v, mdl_v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_turn_left();
    test_crossing();
    test_lost();
    test_stop_and_duty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
